mxint_dequant: RTL

- Converts an MXINT block (BLOCK_SIZE signed mantissas plus one shared biased exponent) back into BLOCK_SIZE plain signed fixed-point values.
- It is the decode side of the MXINT cast/quantise path. It sits at attention-datapath outputs where downstream logic (softmax, accumulation, debug readback) needs ordinary fixed-point.
- It is a two-stage valid/ready pipeline with full backpressure, saturation and a block-level overflow flag.

---
 rtl/mxint_dequant_if.sv | 27 ++
 rtl/mxint_dequant.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mxint_dequant_if.sv
// Stream bundle for the MXINT dequantiser: the input block handshake plus the
// fixed-point result handshake, with master (producer/consumer side) and slave (DUT) views.
interface mxint_dequant_if #(
    parameter int IN_MAN_WIDTH = 8,
    parameter int IN_EXP_WIDTH = 8,
    parameter int OUT_WIDTH    = 16,
    parameter int BLOCK_SIZE   = 4
);
    logic signed [IN_MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE];
    logic        [IN_EXP_WIDTH-1:0] edata_in;
    logic                           data_in_valid;
    logic                           data_in_ready;
    logic signed [OUT_WIDTH-1:0]    data_out [BLOCK_SIZE];
    logic                           sat_out;
    logic                           data_out_valid;
    logic                           data_out_ready;

    modport master (
        output mdata_in, edata_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, sat_out, data_out_valid
    );

    modport slave (
        input  mdata_in, edata_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, sat_out, data_out_valid
    );
endinterface

// File: rtl/mxint_dequant.sv
// MXINT block -> signed fixed-point, two-stage valid/ready pipeline with saturation.
// Define MXINT_DEQUANT_ROUND_EN to round right shifts half-up instead of truncating.
module mxint_dequant #(
    parameter int IN_MAN_WIDTH      = 8,
    parameter int IN_MAN_FRAC_WIDTH = 6,
    parameter int IN_EXP_WIDTH      = 8,
    parameter int OUT_WIDTH         = 16,
    parameter int OUT_FRAC_WIDTH    = 8,
    parameter int BLOCK_SIZE        = 4
) (
    input  logic           clk,
    input  logic           rst,
    mxint_dequant_if.slave bus
);
    localparam int BIAS = (1 << (IN_EXP_WIDTH - 1)) - 1;
    localparam int SW   = IN_EXP_WIDTH + 2;
    localparam int WW   = OUT_WIDTH + IN_MAN_WIDTH;
    localparam int RNW  = IN_MAN_WIDTH + 2;
    localparam int KMAX = IN_MAN_WIDTH + 1;
    localparam int LW   = $clog2(OUT_WIDTH + 1);
    localparam int KW   = $clog2(KMAX + 1);

    localparam logic signed [WW-1:0]        WMAX = WW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [WW-1:0]        WMIN = ~WMAX;
    localparam logic signed [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                           s1_valid;
    logic                           s2_valid;
    logic                           s1_adv;
    logic                           in_ready;
    logic signed [IN_MAN_WIDTH-1:0] s1_man [BLOCK_SIZE];
    logic signed [SW-1:0]           s1_shift;
    logic signed [SW-1:0]           shift_in;
    logic signed [SW-1:0]           neg_shift;
    logic                           big_shift;
    logic        [LW-1:0]           lsh;
    logic        [KW-1:0]           k;
    logic signed [WW-1:0]           wide [BLOCK_SIZE];
    logic signed [RNW-1:0]          rsh [BLOCK_SIZE];
    logic signed [OUT_WIDTH-1:0]    res [BLOCK_SIZE];
    logic        [BLOCK_SIZE-1:0]   sat_e;
    logic signed [OUT_WIDTH-1:0]    out_r [BLOCK_SIZE];
    logic                           sat_r;
`ifdef MXINT_DEQUANT_ROUND_EN
    logic signed [RNW-1:0]          rnd_add;
`endif

    assign s1_adv   = !s2_valid || bus.data_out_ready;
    assign in_ready = !s1_valid || s1_adv;

    assign bus.data_in_ready  = in_ready;
    assign bus.data_out       = out_r;
    assign bus.sat_out        = sat_r;
    assign bus.data_out_valid = s2_valid;

    // Net shift from mantissa LSB weight to output LSB weight.
    assign shift_in = $signed({2'b00, bus.edata_in}) - SW'(BIAS)
                      + SW'(OUT_FRAC_WIDTH - IN_MAN_FRAC_WIDTH);

    always_comb begin
        neg_shift = -s1_shift;
        big_shift = s1_shift > SW'(OUT_WIDTH);
        lsh       = s1_shift[LW-1:0];
        k         = (neg_shift > SW'(KMAX)) ? KW'(KMAX) : neg_shift[KW-1:0];
`ifdef MXINT_DEQUANT_ROUND_EN
        rnd_add   = RNW'(1) << (k - KW'(1));
`endif
    end

    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            wide[i]  = WW'(s1_man[i]) <<< lsh;
`ifdef MXINT_DEQUANT_ROUND_EN
            rsh[i]   = (RNW'(s1_man[i]) + rnd_add) >>> k;
`else
            rsh[i]   = RNW'(s1_man[i]) >>> k;
`endif
            res[i]   = '0;
            sat_e[i] = 1'b0;
            if (!s1_shift[SW-1]) begin
                // lsh is only meaningful when the shift fits, big_shift covers the rest
                if (s1_man[i] == '0) begin
                    res[i] = '0;
                end else if (big_shift || (wide[i] > WMAX) || (wide[i] < WMIN)) begin
                    sat_e[i] = 1'b1;
                    res[i]   = s1_man[i][IN_MAN_WIDTH-1] ? OMIN : OMAX;
                end else begin
                    res[i] = wide[i][OUT_WIDTH-1:0];
                end
            end else begin
                res[i] = OUT_WIDTH'(rsh[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_shift <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) s1_man[i] <= '0;
        end else if (in_ready) begin
            s1_valid <= bus.data_in_valid;
            if (bus.data_in_valid) begin
                s1_man   <= bus.mdata_in;
                s1_shift <= shift_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            sat_r    <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) out_r[i] <= '0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_r <= res;
                sat_r <= |sat_e;
            end
        end
    end
endmodule
